dbus_ctrl: RTL and testbench

Data-bus controller sitting directly downstream of the RV32I core's memory stage. It decodes each core load/store into the RAM or UART target and generates RAM byte enables and lane-shifted write data. It returns aligned, sign/zero-extended load data with the fixed two-cycle latency the core's write-back stage expects. It also owns the UART TX FIFO and the RX holding register.

---
 rtl/dbus_pkg.sv | 38 +++
 rtl/dbus_if.sv | 26 ++
 rtl/dbus_tx_fifo.sv | 47 ++++
 rtl/dbus_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_dbus_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dbus_pkg.sv
`default_nettype none
// ============================================================================
// Module : dbus_pkg
// Shared types and constants for the data-bus controller slice.
// Rev    : 1.0
// ============================================================================
package dbus_pkg;

    typedef enum logic [1:0] {
        TGT_RAM  = 2'd0,
        TGT_UART = 2'd1,
        TGT_NONE = 2'd2
    } tgt_t;

    // UART register window offsets
    localparam logic [3:0] c_REG_TXDATA = 4'h0;
    localparam logic [3:0] c_REG_STATUS = 4'h4;
    localparam logic [3:0] c_REG_RXDATA = 4'h8;
    localparam logic [3:0] c_REG_RSVD   = 4'hC;

    // STATUS register bit positions
    localparam int c_ST_TXNF   = 0;
    localparam int c_ST_RXV    = 1;
    localparam int c_ST_CNTLO  = 2;
    localparam int c_ST_CNTHI  = 4;
    localparam int c_ST_TXOVF  = 5;
    localparam int c_ST_RXOVR  = 6;

    // RamMode bit positions: {byte, half, word, unsigned}
    localparam int c_MODE_BYTE = 3;
    localparam int c_MODE_HALF = 2;
    localparam int c_MODE_WORD = 1;
    localparam int c_MODE_UNS  = 0;

    localparam logic [31:0] c_UART_BASE_DEFAULT = 32'h1000_0000;

endpackage
`default_nettype wire

// File: rtl/dbus_if.sv
`default_nettype none
// ============================================================================
// Module : dbus_if
// Core-side load/store bus between the memory stage and the bus controller.
// Rev    : 1.0
// ============================================================================
interface dbus_if;
    logic [31:0] addr;
    logic [31:0] dataBusOut;
    logic        wrEn;
    logic        rdEn;
    logic [3:0]  RamMode;
    logic [31:0] dataBusIn;
    logic        dataBusInEn;

    modport master (
        output addr, dataBusOut, wrEn, rdEn, RamMode,
        input  dataBusIn, dataBusInEn
    );

    modport slave (
        input  addr, dataBusOut, wrEn, rdEn, RamMode,
        output dataBusIn, dataBusInEn
    );
endinterface
`default_nettype wire

// File: rtl/dbus_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module : dbus_tx_fifo
// Byte FIFO for UART transmit; pointers carry an extra wrap bit.
// Rev    : 1.0
// ============================================================================
module dbus_tx_fifo #(
    parameter int TX_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rstB,
    input  logic                      i_push,
    input  logic                      i_pop,
    input  logic [7:0]                i_wrData,
    output logic [7:0]                o_rdData,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [$clog2(TX_DEPTH):0] o_count
);
    localparam int c_AW = $clog2(TX_DEPTH);

    logic [7:0]  r_mem [TX_DEPTH];
    logic [c_AW:0] r_wrPtr;
    logic [c_AW:0] r_rdPtr;

    always_ff @(posedge clk) begin
        if (!rstB) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (i_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (i_pop)  r_rdPtr <= r_rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wrPtr[c_AW-1:0]] <= i_wrData;
    end

    assign o_rdData = r_mem[r_rdPtr[c_AW-1:0]];
    assign o_empty  = (r_wrPtr == r_rdPtr);
    assign o_full   = (r_wrPtr[c_AW] != r_rdPtr[c_AW]) &&
                      (r_wrPtr[c_AW-1:0] == r_rdPtr[c_AW-1:0]);
    assign o_count  = r_wrPtr - r_rdPtr;

endmodule
`default_nettype wire

// File: rtl/dbus_ctrl.sv
`default_nettype none
// ============================================================================
// Module : dbus_ctrl
// Decodes core loads/stores to RAM or UART; two-cycle fixed load return.
// Rev    : 1.0
// ============================================================================
module dbus_ctrl
    import dbus_pkg::*;
#(
    parameter int          RAM_BYTES = 4096,
    parameter logic [31:0] UART_BASE = c_UART_BASE_DEFAULT,
    parameter int          TX_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rstB,
    input  logic                           clkEn,
    dbus_if.slave                          bus,
    output logic [$clog2(RAM_BYTES)-3:0]   ram_addr,
    output logic [31:0]                    ram_wdata,
    output logic [3:0]                     ram_be,
    output logic                           ram_we,
    output logic                           ram_re,
    input  logic [31:0]                    ram_rdata,
    output logic [7:0]                     uart_tx_data,
    output logic                           uart_tx_valid,
    input  logic                           uart_tx_ready,
    input  logic [7:0]                     uart_rx_data,
    input  logic                           uart_rx_valid,
    output logic                           bus_err
);
    localparam int c_RAM_AW = $clog2(RAM_BYTES);
    localparam int c_CNT_W  = $clog2(TX_DEPTH) + 1;

    logic w_wr, w_rd, w_isRam, w_isUart, w_legal, w_ramOk, w_err;
    logic [3:0] w_regOff;

    assign w_wr     = clkEn & bus.wrEn;
    assign w_rd     = clkEn & bus.rdEn & ~bus.wrEn;
    assign w_isRam  = (bus.addr[31:c_RAM_AW] == '0);
    assign w_isUart = (bus.addr[31:4] == UART_BASE[31:4]);
    assign w_regOff = {bus.addr[3:2], 2'b00};
    assign w_legal  = $onehot(bus.RamMode[c_MODE_BYTE:c_MODE_WORD]) &&
                      !(bus.RamMode[c_MODE_HALF] && bus.addr[0]) &&
                      !(bus.RamMode[c_MODE_WORD] && (bus.addr[1:0] != 2'b00));
    assign w_ramOk  = rstB & w_isRam & w_legal;
    assign w_err    = (w_wr | w_rd) & ((!w_isRam && !w_isUart) || (w_isRam && !w_legal));

    // RAM strobes and lane steering are combinational in the request cycle
    assign ram_we   = w_wr & w_ramOk;
    assign ram_re   = w_rd & w_ramOk;
    assign ram_addr = bus.addr[c_RAM_AW-1:2];

    always_comb begin
        ram_be    = 4'hF;
        ram_wdata = bus.dataBusOut;
        if (bus.RamMode[c_MODE_BYTE]) begin
            ram_be    = 4'b0001 << bus.addr[1:0];
            ram_wdata = {4{bus.dataBusOut[7:0]}};
        end else if (bus.RamMode[c_MODE_HALF]) begin
            ram_be    = 4'b0011 << bus.addr[1:0];
            ram_wdata = {2{bus.dataBusOut[15:0]}};
        end
    end

    // UART register file
    logic w_txFull, w_txEmpty, w_txPop, w_txWant, w_txPush, w_txOvfSet, w_stClr, w_rxRead;
    logic [c_CNT_W-1:0] w_txCount;
    logic [2:0]  w_cntSat;
    logic [31:0] w_status, w_uartRd;
    logic        r_rxValid, r_txOvf, r_rxOvr;
    logic [7:0]  r_rxData;

    assign w_txPop    = uart_tx_valid & uart_tx_ready;
    assign w_txWant   = w_wr & w_isUart & (w_regOff == c_REG_TXDATA);
    assign w_txPush   = w_txWant & (~w_txFull | w_txPop);
    assign w_txOvfSet = w_txWant & w_txFull & ~w_txPop;
    assign w_stClr    = w_wr & w_isUart & (w_regOff == c_REG_STATUS);
    assign w_rxRead   = w_rd & w_isUart & (w_regOff == c_REG_RXDATA);
    assign w_cntSat   = (32'(w_txCount) > 32'd7) ? 3'd7 : 3'(w_txCount);

    always_comb begin
        w_status                       = '0;
        w_status[c_ST_TXNF]            = ~w_txFull;
        w_status[c_ST_RXV]             = r_rxValid;
        w_status[c_ST_CNTHI:c_ST_CNTLO] = w_cntSat;
        w_status[c_ST_TXOVF]           = r_txOvf;
        w_status[c_ST_RXOVR]           = r_rxOvr;
        case (w_regOff)
            c_REG_STATUS: w_uartRd = w_status;
            c_REG_RXDATA: w_uartRd = {24'b0, r_rxData};
            default:      w_uartRd = '0;
        endcase
    end

    dbus_tx_fifo #(.TX_DEPTH(TX_DEPTH)) u_txFifo (
        .clk      (clk),
        .rstB     (rstB),
        .i_push   (w_txPush),
        .i_pop    (w_txPop),
        .i_wrData (bus.dataBusOut[7:0]),
        .o_rdData (uart_tx_data),
        .o_full   (w_txFull),
        .o_empty  (w_txEmpty),
        .o_count  (w_txCount)
    );

    assign uart_tx_valid = ~w_txEmpty;

    // A concurrent RXDATA read consumes the old byte, so it is not an overrun
    always_ff @(posedge clk) begin
        if (!rstB) begin
            r_rxValid <= 1'b0;
            r_rxData  <= '0;
            r_txOvf   <= 1'b0;
            r_rxOvr   <= 1'b0;
        end else begin
            if (w_stClr) begin
                r_txOvf <= 1'b0;
                r_rxOvr <= 1'b0;
            end
            if (w_txOvfSet) r_txOvf <= 1'b1;
            if (uart_rx_valid) begin
                r_rxData  <= uart_rx_data;
                r_rxValid <= 1'b1;
                if (r_rxValid && !w_rxRead) r_rxOvr <= 1'b1;
            end else if (w_rxRead) begin
                r_rxValid <= 1'b0;
            end
        end
    end

    // Load return pipeline: request -> stage 1 -> dataBusIn
    logic        r_s1Valid, r_s1Byte, r_s1Half, r_s1Uns, r_busErr;
    tgt_t        r_s1Tgt;
    logic [1:0]  r_s1Off;
    logic [31:0] r_s1Data, w_shifted, w_loadData;

    assign w_shifted = ram_rdata >> {r_s1Off, 3'b000};

    always_comb begin
        w_loadData = '0;
        case (r_s1Tgt)
            TGT_RAM: begin
                if (r_s1Byte)      w_loadData = {{24{~r_s1Uns & w_shifted[7]}},  w_shifted[7:0]};
                else if (r_s1Half) w_loadData = {{16{~r_s1Uns & w_shifted[15]}}, w_shifted[15:0]};
                else               w_loadData = w_shifted;
            end
            TGT_UART: w_loadData = r_s1Data;
            default:  w_loadData = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstB) begin
            r_s1Valid       <= 1'b0;
            r_s1Tgt         <= TGT_NONE;
            r_s1Off         <= '0;
            r_s1Byte        <= 1'b0;
            r_s1Half        <= 1'b0;
            r_s1Uns         <= 1'b0;
            r_s1Data        <= '0;
            r_busErr        <= 1'b0;
            bus.dataBusIn   <= '0;
            bus.dataBusInEn <= 1'b0;
        end else begin
            r_s1Valid <= w_rd;
            if (w_rd && w_ramOk)       r_s1Tgt <= TGT_RAM;
            else if (w_rd && w_isUart) r_s1Tgt <= TGT_UART;
            else                       r_s1Tgt <= TGT_NONE;
            r_s1Off         <= bus.addr[1:0];
            r_s1Byte        <= bus.RamMode[c_MODE_BYTE];
            r_s1Half        <= bus.RamMode[c_MODE_HALF];
            r_s1Uns         <= bus.RamMode[c_MODE_UNS];
            r_s1Data        <= w_uartRd;
            r_busErr        <= w_err;
            bus.dataBusInEn <= r_s1Valid;
            bus.dataBusIn   <= r_s1Valid ? w_loadData : '0;
        end
    end

    assign bus_err = r_busErr;

endmodule
`default_nettype wire

// File: tb/tb_dbus_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_dbus_ctrl
// Self-checking bench: byte-level reference model plus pinned literal results.
// Rev    : 1.0
// ============================================================================
module tb_dbus_ctrl;
    localparam logic [31:0] UBASE = 32'h1000_0000;
    localparam int          DEPTH = 4;
    localparam logic [3:0]  MB = 4'b1000, MH = 4'b0100, MW = 4'b0010, MU = 4'b0001;

    logic clk = 1'b0, rstB = 1'b0, clkEn = 1'b0;
    always #5 clk = ~clk;

    dbus_if bus ();
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [3:0]  ram_be;
    logic        ram_we, ram_re, uart_tx_valid, uart_tx_ready, uart_rx_valid, bus_err;
    logic [7:0]  uart_tx_data, uart_rx_data;

    dbus_ctrl #(.RAM_BYTES(4096), .UART_BASE(UBASE), .TX_DEPTH(DEPTH)) dut (
        .clk(clk), .rstB(rstB), .clkEn(clkEn), .bus(bus),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_we(ram_we),
        .ram_re(ram_re), .ram_rdata(ram_rdata),
        .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .bus_err(bus_err)
    );

    // Synchronous-read, read-first RAM
    logic [31:0] ramArr [1024];
    always @(posedge clk) begin
        if (ram_re) ram_rdata <= ramArr[ram_addr];
        if (ram_we)
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) ramArr[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end

    int checks = 0, failures = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model state
    logic [7:0]  refMem [4096];
    logic [7:0]  q[$], popped[$];
    bit          txOvf, rxOvr, rxValid;
    logic [7:0]  rxData;
    bit          expEn [4096], expErr [4096], pinEn [4096];
    logic [31:0] expData [4096], pinVal [4096];

    bit rstReq = 0, tbEn = 1, tbReady = 0, rxPulse = 0, pinSt = 0;
    logic [7:0]  rxByte = '0;
    logic [3:0]  pinBe = '0;
    logic [31:0] pinWd = '0;

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < 4096) begin
            check("dataBusInEn", {31'b0, bus.dataBusInEn}, {31'b0, expEn[cyc]});
            check("bus_err", {31'b0, bus_err}, {31'b0, expErr[cyc]});
            if (expEn[cyc]) check("dataBusIn", bus.dataBusIn, expData[cyc]);
            if (pinEn[cyc]) check("pinned_load", bus.dataBusIn, pinVal[cyc]);
        end
    end

    // kind: 0 idle, 1 load, 2 store, 3 store+load together
    task automatic step(input int kind, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] mode, input bit pin, input logic [31:0] pval);
        int k, nb, cnt;
        bit isRam, isUart, legal, isWr, isRd, err, ramAcc, pop, rxv, rxRead;
        logic [3:0] be;
        logic [31:0] v;
        logic [7:0] rxb;
        @(posedge clk); #2;
        k = cyc;
        rxv = rxPulse; rxb = rxByte; rxPulse = 0;
        rstB = rstReq; clkEn = tbEn;
        bus.addr = a; bus.dataBusOut = d; bus.RamMode = mode;
        bus.wrEn = (kind == 2 || kind == 3); bus.rdEn = (kind == 1 || kind == 3);
        uart_tx_ready = tbReady; uart_rx_valid = rxv; uart_rx_data = rxb;
        #1;
        isWr   = tbEn && (kind == 2 || kind == 3);
        isRd   = tbEn && kind == 1;
        isRam  = a < 32'd4096;
        isUart = a[31:4] == UBASE[31:4];
        nb     = mode[3] ? 1 : (mode[2] ? 2 : 4);
        legal  = ($countones(mode[3:1]) == 1) && (a % nb == 0);
        err    = (isWr || isRd) && ((!isRam && !isUart) || (isRam && !legal));
        ramAcc = rstReq && isRam && legal;
        check("ram_we", {31'b0, ram_we}, {31'b0, isWr && ramAcc});
        check("ram_re", {31'b0, ram_re}, {31'b0, isRd && ramAcc});
        check("uart_tx_valid", {31'b0, uart_tx_valid}, {31'b0, q.size() != 0});
        if (q.size() != 0) check("uart_tx_data", {24'b0, uart_tx_data}, {24'b0, q[0]});
        if ((isWr || isRd) && ramAcc) check("ram_addr", {22'b0, ram_addr}, {22'b0, a[11:2]});
        if (isWr && ramAcc) begin
            be = '0;
            for (int i = 0; i < nb; i++) begin
                be[(a[1:0] + i) % 4] = 1'b1;
                check("ram_wdata_lane", {24'b0, ram_wdata[((a[1:0] + i) % 4)*8 +: 8]}, {24'b0, d[i*8 +: 8]});
                refMem[a[11:0] + i] = d[i*8 +: 8];
            end
            check("ram_be", {28'b0, ram_be}, {28'b0, be});
        end
        if (pinSt) begin
            check("pinned_be", {28'b0, ram_be}, {28'b0, pinBe});
            check("pinned_wdata", ram_wdata, pinWd);
            pinSt = 0;
        end
        v = '0;
        cnt = q.size();
        if (isRd && ramAcc) begin
            for (int i = 0; i < nb; i++) v[i*8 +: 8] = refMem[a[11:0] + i];
            if (!mode[0] && nb < 4 && v[8*nb-1])
                for (int i = nb; i < 4; i++) v[i*8 +: 8] = 8'hFF;
        end else if (isRd && isUart) begin
            if (a[3:2] == 2'd1)
                v = {25'b0, rxOvr, txOvf, (cnt > 7) ? 3'd7 : 3'(cnt), rxValid, cnt < DEPTH};
            else if (a[3:2] == 2'd2)
                v = {24'b0, rxData};
        end
        if (!rstReq) begin
            expEn[k+1] = 0; expErr[k+1] = 0; pinEn[k+1] = 0;
            q.delete(); txOvf = 0; rxOvr = 0; rxValid = 0; rxData = '0;
        end else begin
            expErr[k+1] = err;
            if (isRd) begin
                expEn[k+2] = 1; expData[k+2] = v;
                if (pin) begin pinEn[k+2] = 1; pinVal[k+2] = pval; end
            end
            pop    = tbReady && q.size() != 0;
            rxRead = isRd && isUart && a[3:2] == 2'd2;
            if (pop) popped.push_back(q.pop_front());
            if (isWr && isUart && a[3:2] == 2'd1) begin txOvf = 0; rxOvr = 0; end
            if (isWr && isUart && a[3:2] == 2'd0) begin
                if (q.size() < DEPTH) q.push_back(d[7:0]);
                else txOvf = 1;
            end
            if (rxv) begin
                if (rxValid && !rxRead) rxOvr = 1;
                rxData = rxb; rxValid = 1;
            end else if (rxRead) rxValid = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 32'h0, 32'h0, MW, 0, 32'h0);
    endtask
    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        step(2, a, d, m, 0, 32'h0);
    endtask
    task automatic ld(input logic [31:0] a, input logic [3:0] m);
        step(1, a, 32'h0, m, 0, 32'h0);
    endtask
    task automatic ldp(input logic [31:0] a, input logic [3:0] m, input logic [31:0] pv);
        step(1, a, 32'h0, m, 1, pv);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ramArr[i] = '0;
        for (int i = 0; i < 4096; i++) refMem[i] = '0;
        bus.addr = '0; bus.dataBusOut = '0; bus.wrEn = 0; bus.rdEn = 0; bus.RamMode = MW;
        uart_tx_ready = 0; uart_rx_valid = 0; uart_rx_data = '0;

        rstReq = 0;
        idle(2);
        step(1, 32'h10, 32'h0, MW, 0, 32'h0);     // load under reset must not strobe RAM
        idle(1);
        check("reset_dataBusIn", bus.dataBusIn, 32'h0);
        check("reset_uart_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
        rstReq = 1;

        st(32'h10, 32'hDEADBEEF, MW);
        ldp(32'h13, MB, 32'hFFFFFFDE);
        ldp(32'h13, MB | MU, 32'h000000DE);
        ldp(32'h12, MH | MU, 32'h0000DEAD);
        pinSt = 1; pinBe = 4'b0010; pinWd = 32'hA5A5A5A5;
        st(32'h21, 32'h000000A5, MB);
        ldp(32'h20, MW, 32'h0000A500);
        st(32'h4A, 32'hBEEF1234, MH);
        ldp(32'h48, MW, 32'h12340000);
        ldp(32'h4A, MH, 32'h00001234);

        ldp(32'h3, MH, 32'h0);
        ldp(32'h2, MW, 32'h0);
        ldp(32'h4, MB | MH, 32'h0);
        ldp(32'h2000_0000, MW, 32'h0);
        st(32'h6, 32'h11111111, MW);

        step(3, 32'h40, 32'h12345678, MW, 0, 32'h0);
        ldp(32'h40, MW, 32'h12345678);
        st(32'h40, 32'hCAFEF00D, MW);
        ldp(32'h40, MW, 32'hCAFEF00D);
        tbEn = 0; st(32'h44, 32'hFFFFFFFF, MW); tbEn = 1;
        ldp(32'h44, MW, 32'h0);

        tbReady = 0;
        for (int i = 1; i <= 5; i++) st(UBASE, 32'(i * 8'h11), MW);
        ldp(UBASE + 32'h4, MW, 32'h30);
        tbReady = 1; idle(6); tbReady = 0;
        check("tx_popped_count", 32'(popped.size()), 32'd4);
        for (int i = 0; i < 4 && i < popped.size(); i++)
            check("tx_popped_byte", {24'b0, popped[i]}, 32'(8'h11 * (i + 1)));
        popped.delete();
        ldp(UBASE + 32'h4, MW, 32'h21);
        st(UBASE + 32'h4, 32'h0, MW);
        ldp(UBASE + 32'h4, MW, 32'h01);

        for (int i = 0; i < 4; i++) st(UBASE, 32'(8'h61 + i), MW);
        tbReady = 1; st(UBASE, 32'h65, MW); tbReady = 0;
        ldp(UBASE + 32'h4, MW, 32'h10);
        tbReady = 1; idle(6); tbReady = 0;
        popped.delete();
        st(UBASE + 32'hC, 32'hFF, MW);
        ldp(UBASE + 32'hC, MW, 32'h0);
        tbReady = 1; st(UBASE, 32'h77, MB); idle(3); tbReady = 0;

        rxByte = 8'h41; rxPulse = 1; idle(1);
        rxByte = 8'h42; rxPulse = 1; idle(1);
        ldp(UBASE + 32'h8, MW, 32'h42);
        ldp(UBASE + 32'h4, MW, 32'h41);
        st(UBASE + 32'h4, 32'h0, MW);
        rxByte = 8'h55; rxPulse = 1; idle(1);
        rxByte = 8'h66; rxPulse = 1; ldp(UBASE + 32'h8, MB, 32'h55);
        ld(UBASE + 32'h4, MW);
        ldp(UBASE + 32'h8, MW, 32'h66);

        st(UBASE, 32'h99, MW);
        ld(32'h10, MW);
        rstReq = 0; idle(1); rstReq = 1;
        idle(1);
        check("midreset_dataBusInEn", {31'b0, bus.dataBusInEn}, 32'h0);
        check("midreset_dataBusIn", bus.dataBusIn, 32'h0);
        check("midreset_uart_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
        ldp(UBASE + 32'h4, MW, 32'h01);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
